uart_tx_arbiter: RTL

//  Round-robin scheduler that shares one uart transmitter between NREQ byte sources.
//  It grants one requester, loads that requester's byte with ld_tx_data, and holds tx_enable for the whole frame.
//  On completion (tx_empty returns high) it acks the requester, then inserts an idle gap before the next grant.
//  It sits between the host-side requesters and the uart TX port, in the txclk domain.

---
 rtl/uart_tx_arbiter.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one uart transmitter among
// NREQ byte sources. Grants one requester, loads its byte, holds tx_enable for
// the frame, acks on completion (or watchdog expiry), then idles GAP_CYCLES.
module uart_tx_arbiter #(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned GAP_CYCLES = 1,
  parameter int unsigned WDOG       = 15,
  localparam int unsigned IDXW      = $clog2(NREQ)
) (
  input  logic              txclk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  output logic              err,
  output logic              busy,
  output logic [IDXW-1:0]   grant_idx,
  output logic              ld_tx_data,
  output logic [7:0]        tx_data,
  output logic              tx_enable,
  input  logic              tx_empty
);

  localparam int unsigned WDW = $clog2(WDOG + 1);
  localparam int unsigned GW  = 4;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_BUSY,
    SEND,
    GAP
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0]   grant_idx_q, grant_idx_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              ld_q, ld_d;
  logic              tx_en_q, tx_en_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic [WDW-1:0]    wdog_q, wdog_d;
  logic [GW-1:0]     gap_q, gap_d;

  logic [7:0]        req_bytes [NREQ];
  logic [NREQ-1:0]   cand;
  logic              pick_ok;
  logic [IDXW-1:0]   pick_idx;
  logic              frame_end;
  logic              wdog_hit;

  // Unpack the flat byte bus into one byte per requester
  for (genvar g = 0; g < NREQ; g++) begin : g_bytes
    assign req_bytes[g] = req_data[8*g +: 8];
  end

  // Round-robin pick: first candidate after ptr, wrapping; a requester whose
  // ack is still high is masked so a late req drop cannot re-win.
  // Scanning from the farthest position down lets the nearest one win last.
  always_comb begin
    int unsigned pos;
    cand     = req & ~ack_q;
    pick_ok  = 1'b0;
    pick_idx = '0;
    pos      = 0;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      pos = 32'(ptr_q) + k;
      if (pos >= NREQ) pos = pos - NREQ;
      if (cand[IDXW'(pos)]) begin
        pick_ok  = 1'b1;
        pick_idx = IDXW'(pos);
      end
    end
  end

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    tx_data_d   = tx_data_q;
    ld_d        = 1'b0;
    tx_en_d     = tx_en_q;
    ack_d       = '0;
    err_d       = 1'b0;
    wdog_d      = wdog_q;
    gap_d       = gap_q;
    frame_end   = 1'b0;
    wdog_hit    = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_empty && pick_ok) begin
          ptr_d       = pick_idx;
          grant_idx_d = pick_idx;
          tx_data_d   = req_bytes[pick_idx];
          ld_d        = 1'b1;
          tx_en_d     = 1'b1;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        tx_en_d = 1'b1;
        wdog_d  = '0;
        state_d = WAIT_BUSY;
      end
      // wdog holds the cycles elapsed since LOAD minus one, so the limit is
      // detected one count early to end the frame exactly WDOG cycles after LOAD
      WAIT_BUSY: begin
        wdog_d = wdog_q + 1'b1;
        if (wdog_q == WDW'(WDOG - 1)) begin
          wdog_hit = 1'b1;
        end else if (!tx_empty) begin
          state_d = SEND;
        end
      end
      SEND: begin
        wdog_d = wdog_q + 1'b1;
        if (tx_empty) begin
          frame_end = 1'b1;
        end else if (wdog_q == WDW'(WDOG - 1)) begin
          wdog_hit = 1'b1;
        end
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Completion and watchdog expiry share the same frame teardown
    if (frame_end || wdog_hit) begin
      ack_d[grant_idx_q] = 1'b1;
      err_d              = wdog_hit;
      tx_en_d            = 1'b0;
      gap_d              = '0;
      state_d            = (GAP_CYCLES == 0) ? IDLE : GAP;
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset drops any frame in flight
  always_ff @(posedge txclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= IDXW'(NREQ - 1);
      grant_idx_q <= '0;
      tx_data_q   <= '0;
      ld_q        <= 1'b0;
      tx_en_q     <= 1'b0;
      ack_q       <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      wdog_q      <= '0;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      tx_data_q   <= tx_data_d;
      ld_q        <= ld_d;
      tx_en_q     <= tx_en_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      wdog_q      <= wdog_d;
      gap_q       <= gap_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign grant_idx  = grant_idx_q;
  assign ld_tx_data = ld_q;
  assign tx_data    = tx_data_q;
  assign tx_enable  = tx_en_q;

endmodule
